// File: rtl/rec_buf_rd_drain_pkg.sv
// Shared constants and types for the reconstruction-buffer read drain.
// Plane codes, block size code, row geometry and the FSM state type.
package rec_buf_rd_drain_pkg;

    localparam int PIXEL_WIDTH  = 8;
    localparam int ROW_W        = PIXEL_WIDTH * 32;
    localparam int TAG_W        = 10;
    localparam int ROWS_PER_LCU = 192;
    localparam int LUMA_READS   = 128;
    localparam int CHROMA_READS = 32;

    localparam logic [1:0] SEL_Y  = 2'd0;
    localparam logic [1:0] SEL_U  = 2'd2;
    localparam logic [1:0] SEL_V  = 2'd3;
    localparam logic [1:0] SIZ_32 = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LUMA,
        ST_CB,
        ST_CR,
        ST_WAIT
    } drain_state_t;

    typedef struct packed {
        logic [1:0] sel;
        logic [5:0] row;
        logic       half;
        logic       last;
    } row_tag_t;

endpackage

// File: rtl/rec_buf_rd_fifo.sv
// Small synchronous skid FIFO holding read rows plus their tags.
// Simultaneous push and pop is legal at any fill level.
module rec_buf_rd_fifo #(
    parameter int DEP = 2,
    parameter int W   = 8,
    localparam int PW = $clog2(DEP),
    localparam int CW = $clog2(DEP + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] cnt
);

    logic [W-1:0]  mem [DEP];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEP - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEP; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= nxt(wr_ptr);
            end
            if (pop) rd_ptr <= nxt(rd_ptr);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/rec_buf_rd_drain.sv
// Drains one finished LCU (Y 64x64, Cb 32x32, Cr 32x32) from the buffer
// read port as 32-pixel rows, credit-limited to the skid FIFO depth.
module rec_buf_rd_drain
    import rec_buf_rd_drain_pkg::*;
#(
    parameter int FIFO_DEP = 2,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             rd_ena_o,
    output logic [1:0]       rd_sel_o,
    output logic [1:0]       rd_siz_o,
    output logic [3:0]       rd_4x4_x_o,
    output logic [3:0]       rd_4x4_y_o,
    output logic [4:0]       rd_idx_o,
    input  logic [ROW_W-1:0] rd_dat_i,
    output logic             out_val_o,
    input  logic             out_rdy_i,
    output logic [1:0]       out_sel_o,
    output logic [5:0]       out_row_o,
    output logic             out_half_o,
    output logic             out_last_o,
    output logic [ROW_W-1:0] out_dat_o
);

    localparam int CW = $clog2(FIFO_DEP + 1);

    drain_state_t         state;
    logic [CNT_W-1:0]     cnt;
    logic                 inflight;
    row_tag_t             tag_q;
    row_tag_t             cur_tag;
    row_tag_t             out_tag;
    logic [CW-1:0]        fifo_cnt;
    logic [TAG_W+ROW_W-1:0] fifo_dout;
    logic                 active;
    logic                 pop;
    logic                 phase_end;
    logic [CW:0]          pending;

    assign active    = state inside {ST_LUMA, ST_CB, ST_CR};
    assign out_val_o = fifo_cnt != '0;
    assign pop       = out_val_o & out_rdy_i;

    // Rows in the FIFO plus the read still in the buffer pipeline.
    assign pending  = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight}
                    - {{CW{1'b0}}, pop};
    assign rd_ena_o = active && (pending < (CW + 1)'(FIFO_DEP));

    always_comb begin
        rd_sel_o   = '0;
        rd_siz_o   = '0;
        rd_4x4_x_o = '0;
        rd_4x4_y_o = '0;
        rd_idx_o   = '0;
        cur_tag    = '0;
        phase_end  = 1'b0;
        unique case (state)
            ST_LUMA: begin
                phase_end    = cnt == CNT_W'(LUMA_READS - 1);
                rd_4x4_x_o   = cnt[0] ? 4'd8 : 4'd0;
                rd_4x4_y_o   = cnt[6] ? 4'd8 : 4'd0;
                rd_idx_o     = cnt[5:1];
                cur_tag.sel  = SEL_Y;
                cur_tag.row  = cnt[6:1];
                cur_tag.half = cnt[0];
            end
            ST_CB, ST_CR: begin
                phase_end    = cnt == CNT_W'(CHROMA_READS - 1);
                rd_idx_o     = cnt[4:0];
                cur_tag.sel  = (state == ST_CB) ? SEL_U : SEL_V;
                cur_tag.row  = {1'b0, cnt[4:0]};
                cur_tag.last = (state == ST_CR) && phase_end;
            end
            default: ;
        endcase
        if (active) begin
            rd_sel_o = cur_tag.sel;
            rd_siz_o = SIZ_32;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            inflight <= 1'b0;
            tag_q    <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            done_o   <= 1'b0;
            inflight <= rd_ena_o;
            if (rd_ena_o) tag_q <= cur_tag;
            unique case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        state  <= ST_LUMA;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                    end
                end
                ST_LUMA, ST_CB, ST_CR: begin
                    if (rd_ena_o) begin
                        if (phase_end) begin
                            cnt <= '0;
                            unique case (state)
                                ST_LUMA: state <= ST_CB;
                                ST_CB:   state <= ST_CR;
                                default: state <= ST_WAIT;
                            endcase
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (pop && out_last_o) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    rec_buf_rd_fifo #(
        .DEP (FIFO_DEP),
        .W   (TAG_W + ROW_W)
    ) u_fifo (
        .clk  (clk),
        .rstn (rstn),
        .push (inflight),
        .pop  (pop),
        .din  ({tag_q, rd_dat_i}),
        .dout (fifo_dout),
        .cnt  (fifo_cnt)
    );

    assign {out_tag, out_dat_o} = fifo_dout;
    assign out_sel_o  = out_tag.sel;
    assign out_row_o  = out_tag.row;
    assign out_half_o = out_tag.half;
    assign out_last_o = out_tag.last;

endmodule

// File: tb/tb_rec_buf_rd_drain.sv
// Bench for rec_buf_rd_drain: random backpressure against a row-sequence
// model of the LCU drain, plus a few hand-computed timing and address pins.
module tb_rec_buf_rd_drain;
    import rec_buf_rd_drain_pkg::*;

    localparam int DEP = 2;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start_i = 1'b0;
    logic             out_rdy_i = 1'b0;
    logic [ROW_W-1:0] rd_dat_i = '0;
    logic             busy_o, done_o, rd_ena_o;
    logic [1:0]       rd_sel_o, rd_siz_o;
    logic [3:0]       rd_4x4_x_o, rd_4x4_y_o;
    logic [4:0]       rd_idx_o;
    logic             out_val_o, out_half_o, out_last_o;
    logic [1:0]       out_sel_o;
    logic [5:0]       out_row_o;
    logic [ROW_W-1:0] out_dat_o;

    always #5 clk = ~clk;

    rec_buf_rd_drain #(.FIFO_DEP(DEP), .CNT_W(8)) u_dut (
        .clk(clk), .rstn(rstn), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o),
        .rd_ena_o(rd_ena_o), .rd_sel_o(rd_sel_o), .rd_siz_o(rd_siz_o),
        .rd_4x4_x_o(rd_4x4_x_o), .rd_4x4_y_o(rd_4x4_y_o),
        .rd_idx_o(rd_idx_o), .rd_dat_i(rd_dat_i),
        .out_val_o(out_val_o), .out_rdy_i(out_rdy_i),
        .out_sel_o(out_sel_o), .out_row_o(out_row_o),
        .out_half_o(out_half_o), .out_last_o(out_last_o),
        .out_dat_o(out_dat_o)
    );

    int n_chk = 0;
    int n_err = 0;
    bit busy_m, done_m, p1;
    int iss_n, pop_n, vis_n;
    int n_done, n_ena, n_pin;
    logic pend = 1'b0;
    logic [ROW_W-1:0] pend_dat;

    typedef struct {
        logic [1:0] sel;
        logic [5:0] row;
        logic       half;
        logic       last;
        logic [3:0] x;
        logic [3:0] y;
        logic [4:0] idx;
    } erow_t;

    // k-th row of an LCU drain in transfer order.
    function automatic erow_t row_of(input int k);
        erow_t e;
        int r;
        if (k < 128) begin
            r      = k / 2;
            e.sel  = 2'd0;
            e.half = 1'(k % 2);
            e.x    = e.half ? 4'd8 : 4'd0;
            e.y    = (r >= 32) ? 4'd8 : 4'd0;
            e.idx  = 5'(r % 32);
        end else begin
            r      = (k < 160) ? k - 128 : k - 160;
            e.sel  = (k < 160) ? 2'd2 : 2'd3;
            e.half = 1'b0;
            e.x    = 4'd0;
            e.y    = 4'd0;
            e.idx  = 5'(r);
        end
        e.row  = 6'(r);
        e.last = (k == ROWS_PER_LCU - 1);
        return e;
    endfunction

    function automatic logic [ROW_W-1:0] pix(input logic [1:0] s,
                                             input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic [4:0] i);
        logic [ROW_W-1:0] d;
        for (int p = 0; p < 32; p++)
            d[p*PIXEL_WIDTH +: PIXEL_WIDTH] =
                PIXEL_WIDTH'(37 * s + 11 * x + 7 * y + 3 * i + 5 * p + 1);
        return d;
    endfunction

    function automatic logic [ROW_W-1:0] garbage();
        logic [ROW_W-1:0] d;
        for (int p = 0; p < ROW_W / 32; p++) d[p*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic chk(input string nm, input logic [ROW_W-1:0] act,
                       input logic [ROW_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        busy_m = 0; done_m = 0; p1 = 0;
        iss_n = 0; pop_n = 0; vis_n = 0;
        pend = 1'b0;
    endtask

    task automatic monitor();
        bit    pop_now, exp_ena, was_busy;
        erow_t e;
        if (!rstn) begin
            chk("rst_ctl", {busy_o, done_o, rd_ena_o, rd_sel_o, rd_siz_o,
                            rd_4x4_x_o, rd_4x4_y_o, rd_idx_o}, '0);
            chk("rst_out", {out_val_o, out_sel_o, out_row_o,
                            out_half_o, out_last_o}, '0);
            chk("rst_dat", out_dat_o, '0);
            model_reset();
            return;
        end
        chk("busy", busy_o, busy_m);
        chk("done", done_o, done_m);
        if (done_o) n_done++;
        pop_now = (vis_n > pop_n) && out_rdy_i;
        exp_ena = busy_m && iss_n < ROWS_PER_LCU &&
                  (iss_n - pop_n - (pop_now ? 1 : 0)) < DEP;
        chk("rd_ena", rd_ena_o, exp_ena);
        if (rd_ena_o && iss_n < ROWS_PER_LCU) begin
            n_ena++;
            e = row_of(iss_n);
            chk("rd_sel", rd_sel_o, e.sel);
            chk("rd_siz", rd_siz_o, 2'd3);
            chk("rd_x", rd_4x4_x_o, e.x);
            chk("rd_y", rd_4x4_y_o, e.y);
            chk("rd_idx", rd_idx_o, e.idx);
            if (iss_n == 81) begin
                n_pin++;
                chk("pin_y40h1", {rd_sel_o, rd_siz_o, rd_4x4_x_o,
                                  rd_4x4_y_o, rd_idx_o},
                    {2'd0, 2'd3, 4'd8, 4'd8, 5'd8});
            end
            if (iss_n == 165) begin
                n_pin++;
                chk("pin_cr5", {rd_sel_o, rd_siz_o, rd_4x4_x_o,
                                rd_4x4_y_o, rd_idx_o},
                    {2'd3, 2'd3, 4'd0, 4'd0, 5'd5});
            end
        end
        chk("out_val", out_val_o, vis_n > pop_n);
        if (out_val_o && pop_n < ROWS_PER_LCU) begin
            e = row_of(pop_n);
            chk("out_tag", {out_sel_o, out_row_o, out_half_o, out_last_o},
                {e.sel, e.row, e.half, e.last});
            chk("out_dat", out_dat_o, pix(e.sel, e.x, e.y, e.idx));
        end
        pend     = rd_ena_o;
        pend_dat = pix(rd_sel_o, rd_4x4_x_o, rd_4x4_y_o, rd_idx_o);
        was_busy = busy_m;
        done_m   = 0;
        vis_n   += p1 ? 1 : 0;
        p1       = exp_ena;
        if (exp_ena) iss_n++;
        if (pop_now) begin
            pop_n++;
            if (pop_n == ROWS_PER_LCU) begin
                busy_m = 0;
                done_m = 1;
            end
        end
        if (start_i && !was_busy) begin
            busy_m = 1;
            iss_n = 0; pop_n = 0; vis_n = 0; p1 = 0;
        end
    endtask

    // st: plain pulse; stb: pulse only while busy; sod: pulse on done_o.
    task automatic step(input bit st, input bit rdy, input bit sod,
                        input bit stb);
        @(negedge clk);
        start_i   = st | (stb & busy_o) | (sod & done_o);
        out_rdy_i = rdy;
        rd_dat_i  = pend ? pend_dat : garbage();
        #1;
        monitor();
    endtask

    task automatic run(input int rdy_pct, input int st_every,
                       input int want, input int max_cyc);
        int base = n_done;
        for (int i = 0; i < max_cyc && n_done < base + want; i++)
            step(1'b0, $urandom_range(99) < rdy_pct,
                 n_done < base + want - 1,
                 st_every > 0 && (i % st_every) == st_every - 1);
        chk("drain_count", n_done - base, want);
    endtask

    initial begin
        int first, tdone, e0, d0;
        model_reset();
        n_done = 0; n_ena = 0; n_pin = 0;
        repeat (3) step(0, 0, 0, 0);
        rstn = 1'b1;

        step(1, 1, 0, 0);
        first = -1;
        tdone = -1;
        for (int t = 1; t < 400 && tdone < 0; t++) begin
            step(0, 1, 0, 0);
            if (first < 0 && out_val_o) first = t;
            if (done_o) tdone = t;
        end
        chk("first_val_lat", first, 3);
        chk("done_lat", tdone, 195);

        step(1, 1, 0, 0);
        run(50, 0, 1, 3000);

        e0 = n_ena;
        step(1, 0, 0, 0);
        repeat (20) step(0, 0, 0, 0);
        chk("credit_reads", n_ena - e0, DEP);
        run(100, 0, 1, 1000);

        step(1, 1, 0, 0);
        run(60, 7, 2, 4000);

        step(1, 1, 0, 0);
        for (int i = 0; i < 400 && pop_n < 70; i++) step(0, 1, 0, 0);
        chk("row70_reached", pop_n, 70);
        d0   = n_done;
        rstn = 1'b0;
        #1;
        monitor();
        repeat (5) step(0, 1, 0, 0);
        chk("no_done_on_abort", n_done, d0);
        rstn = 1'b1;
        step(1, 1, 0, 0);
        run(100, 0, 1, 1000);

        chk("addr_pins_hit", n_pin >= 2, 1'b1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
